// File: rtl/mult_pkg.sv
// Shared definitions for the iterative multiplier: op and state encodings
// plus the legality check for the per-cycle multiplier width.
package mult_pkg;

    localparam int RD_W = 5;

    typedef enum logic [1:0] {
        MULT_MUL    = 2'b00,
        MULT_MULH   = 2'b01,
        MULT_MULHSU = 2'b10,
        MULT_MULHU  = 2'b11
    } mult_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } mult_state_e;

    function automatic logic bpc_legal(input int bpc);
        case (bpc)
            1, 2, 4, 8: bpc_legal = 1'b1;
            default:    bpc_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mult_iter_unit_if.sv
// Request/response bundle between the EX stage and the iterative multiplier.
interface mult_iter_unit_if #(parameter int DATA_W = 64);
    import mult_pkg::*;

    logic              start;
    logic              flush;
    logic [1:0]        op;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [RD_W-1:0]   rd_in;
    logic              busy;
    logic              stall_req;
    logic              done;
    logic [DATA_W-1:0] result;
    logic [RD_W-1:0]   rd_out;

    modport master (
        output start, flush, op, operand_a, operand_b, rd_in,
        input  busy, stall_req, done, result, rd_out
    );

    modport slave (
        input  start, flush, op, operand_a, operand_b, rd_in,
        output busy, stall_req, done, result, rd_out
    );

endinterface

// File: rtl/mult_iter_unit_step.sv
// One shift-add iteration: adds mag_a times the low multiplier chunk into the
// upper half of the accumulator, then shifts accumulator and multiplier right.
module mult_step #(
    parameter int DATA_W         = 64,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic [2*DATA_W-1:0] acc,
    input  logic [DATA_W-1:0]   mag_a,
    input  logic [DATA_W-1:0]   mul_b,
    output logic [2*DATA_W-1:0] acc_next,
    output logic [DATA_W-1:0]   mul_b_next
);
    localparam int SUM_W = DATA_W + BITS_PER_CYCLE;

    logic [BITS_PER_CYCLE-1:0] chunk_s;
    logic [SUM_W-1:0]          pp_s;
    logic [SUM_W-1:0]          sum_s;

    // The upper half never exceeds DATA_W+BITS_PER_CYCLE bits, so no carry is lost
    always_comb begin
        chunk_s    = mul_b[BITS_PER_CYCLE-1:0];
        pp_s       = {{BITS_PER_CYCLE{1'b0}}, mag_a} * {{DATA_W{1'b0}}, chunk_s};
        sum_s      = {{BITS_PER_CYCLE{1'b0}}, acc[2*DATA_W-1:DATA_W]} + pp_s;
        acc_next   = {sum_s, acc[DATA_W-1:BITS_PER_CYCLE]};
        mul_b_next = mul_b >> BITS_PER_CYCLE;
    end

endmodule

// File: rtl/mult_iter_unit.sv
// Iterative MUL/MULH/MULHSU/MULHU unit: unsigned shift-add on magnitudes with a
// final conditional negate, fixed latency, start/busy/done handshake.
module mult_iter_unit
    import mult_pkg::*;
#(
    parameter int DATA_W         = 64,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             enable,
    mult_iter_unit_if.slave  bus
);
    localparam int ITER  = DATA_W / BITS_PER_CYCLE;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    if (!bpc_legal(BITS_PER_CYCLE) || ((DATA_W % BITS_PER_CYCLE) != 0)) begin : g_bad_cfg
        $error("mult_iter_unit: illegal DATA_W / BITS_PER_CYCLE combination");
    end

    mult_state_e         state_r, state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic                fin_r;
    logic [2*DATA_W-1:0] acc_r, acc_next_s, prod_s;
    logic [DATA_W-1:0]   b_r, b_next_s, mag_a_r, mag_a_s, mag_b_s, sel_s;
    logic                neg_r, neg_s, hi_sel_r, accept_s;
    logic [RD_W-1:0]     rd_r, rd_out_r;
    logic [DATA_W-1:0]   result_r;
    logic                done_r;
    mult_op_e            op_s;

    mult_step #(.DATA_W(DATA_W), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
        .acc        (acc_r),
        .mag_a      (mag_a_r),
        .mul_b      (b_r),
        .acc_next   (acc_next_s),
        .mul_b_next (b_next_s)
    );

    // Operand sign correction and sign of the final product at capture time
    always_comb begin
        op_s     = mult_op_e'(bus.op);
        accept_s = (state_r == ST_IDLE) && bus.start && !bus.flush;
        if (((op_s == MULT_MULH) || (op_s == MULT_MULHSU)) && bus.operand_a[DATA_W-1]) begin
            mag_a_s = ~bus.operand_a + {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
            mag_a_s = bus.operand_a;
        end
        if ((op_s == MULT_MULH) && bus.operand_b[DATA_W-1]) begin
            mag_b_s = ~bus.operand_b + {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
            mag_b_s = bus.operand_b;
        end
        case (op_s)
            MULT_MULH:   neg_s = bus.operand_a[DATA_W-1] ^ bus.operand_b[DATA_W-1];
            MULT_MULHSU: neg_s = bus.operand_a[DATA_W-1];
            default:     neg_s = 1'b0;
        endcase
    end

    // The negate sits in the extra finalise cycle, off the shift-add path
    always_comb begin
        if (neg_r) begin
            prod_s = ~acc_r + {{(2*DATA_W-1){1'b0}}, 1'b1};
        end else begin
            prod_s = acc_r;
        end
        if (hi_sel_r) begin
            sel_s = prod_s[2*DATA_W-1:DATA_W];
        end else begin
            sel_s = prod_s[DATA_W-1:0];
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_CALC;
                else          state_s = ST_IDLE;
            end
            ST_CALC: begin
                if (bus.flush)  state_s = ST_IDLE;
                else if (fin_r) state_s = ST_DONE;
                else            state_s = ST_CALC;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, datapath and output registers; enable low freezes everything
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            fin_r    <= 1'b0;
            acc_r    <= '0;
            b_r      <= '0;
            mag_a_r  <= '0;
            neg_r    <= 1'b0;
            hi_sel_r <= 1'b0;
            rd_r     <= '0;
            result_r <= '0;
            rd_out_r <= '0;
            done_r   <= 1'b0;
        end else if (enable) begin
            state_r <= state_s;
            done_r  <= (state_s == ST_DONE);
            if (accept_s) begin
                mag_a_r  <= mag_a_s;
                b_r      <= mag_b_s;
                neg_r    <= neg_s;
                hi_sel_r <= (op_s != MULT_MUL);
                rd_r     <= bus.rd_in;
                acc_r    <= '0;
                cnt_r    <= '0;
                fin_r    <= 1'b0;
            end else if ((state_r == ST_CALC) && !bus.flush) begin
                if (fin_r) begin
                    result_r <= sel_s;
                    rd_out_r <= rd_r;
                    fin_r    <= 1'b0;
                end else begin
                    acc_r <= acc_next_s;
                    b_r   <= b_next_s;
                    if (cnt_r == CNT_LAST) begin
                        cnt_r <= '0;
                        fin_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1'b1);
                    end
                end
            end
        end
    end

    assign bus.busy      = (state_r == ST_CALC) || (state_r == ST_DONE);
    assign bus.stall_req = accept_s || (state_r == ST_CALC);
    assign bus.done      = done_r;
    assign bus.result    = result_r;
    assign bus.rd_out    = rd_out_r;

endmodule

// File: tb/tb_mult_iter_unit.sv
// Bench for mult_iter_unit: cycle model of the handshake with a wide-arithmetic
// reference product, plus directed scenarios with literal expectations.
module tb_mult_iter_unit;
    import mult_pkg::*;

    localparam int W    = 64;
    localparam int ITER = W / 4;

    logic clk = 1'b0;
    logic arst_n;
    logic enable;
    always #5 clk = ~clk;

    mult_iter_unit_if #(.DATA_W(W)) bus  ();
    mult_iter_unit_if #(.DATA_W(W)) bus1 ();
    mult_iter_unit_if #(.DATA_W(W)) bus8 ();

    mult_iter_unit #(.DATA_W(W), .BITS_PER_CYCLE(4)) dut  (.clk(clk), .arst_n(arst_n), .enable(enable), .bus(bus));
    mult_iter_unit #(.DATA_W(W), .BITS_PER_CYCLE(1)) dut1 (.clk(clk), .arst_n(arst_n), .enable(enable), .bus(bus1));
    mult_iter_unit #(.DATA_W(W), .BITS_PER_CYCLE(8)) dut8 (.clk(clk), .arst_n(arst_n), .enable(enable), .bus(bus8));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb, p;
        sa = ((op == MULT_MULH) || (op == MULT_MULHSU)) ? {{64{a[63]}}, a} : {64'd0, a};
        sb = (op == MULT_MULH) ? {{64{b[63]}}, b} : {64'd0, b};
        p  = sa * sb;
        return (op == MULT_MUL) ? p[63:0] : p[127:64];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: idle / working with remaining-edge count / done
    int          m_phase = 0;
    int          m_rem   = 0;
    logic [63:0] m_result = 64'd0, m_pend = 64'd0;
    logic [4:0]  m_rd = 5'd0, m_pend_rd = 5'd0;

    always @(posedge clk) begin
        if (!arst_n) begin
            m_phase  <= 0;
            m_result <= 64'd0;
            m_rd     <= 5'd0;
        end else if (enable) begin
            case (m_phase)
                0: if (bus.start && !bus.flush) begin
                    m_phase   <= 1;
                    m_rem     <= ITER + 1;
                    m_pend    <= ref_mul(bus.op, bus.operand_a, bus.operand_b);
                    m_pend_rd <= bus.rd_in;
                end
                1: if (bus.flush) m_phase <= 0;
                   else if (m_rem == 1) begin
                       m_phase  <= 2;
                       m_result <= m_pend;
                       m_rd     <= m_pend_rd;
                   end else m_rem <= m_rem - 1;
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("busy",      64'(bus.busy),      64'(m_phase != 0));
        chk("done",      64'(bus.done),      64'(m_phase == 2));
        chk("stall_req", 64'(bus.stall_req), 64'((m_phase == 1) || ((m_phase == 0) && bus.start && !bus.flush)));
        chk("result",    bus.result,         m_result);
        chk("rd_out",    64'(bus.rd_out),    64'(m_rd));
    end

    task automatic start_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
        bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b; bus.rd_in = rd;
        @(posedge clk);
        #1 bus.start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int bound, output int lat, output int stalls);
        lat = -1;
        stalls = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (bus.stall_req) stalls++;
            if (bus.done) begin
                lat = cyc - t0;
                break;
            end
        end
        chk("done_seen", 64'(lat >= 0), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp);
        int lat, st;
        start_op(op, a, b, 5'd6);
        wait_done(200, lat, st);
        chk({name, "_lat"}, 64'(lat), 64'(ITER + 1));
        chk(name, bus.result, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, st, lat1, lat8, dones;
        logic [63:0] r1, r8;
        arst_n = 1'b0; enable = 1'b1;
        bus.start = 1'b0;  bus.flush = 1'b0;  bus.op = 2'b00;  bus.operand_a = 64'd0;  bus.operand_b = 64'd0;  bus.rd_in = 5'd0;
        bus1.start = 1'b0; bus1.flush = 1'b0; bus1.op = 2'b00; bus1.operand_a = 64'd0; bus1.operand_b = 64'd0; bus1.rd_in = 5'd0;
        bus8.start = 1'b0; bus8.flush = 1'b0; bus8.op = 2'b00; bus8.operand_a = 64'd0; bus8.operand_b = 64'd0; bus8.rd_in = 5'd0;
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        chk("reset_result", bus.result, 64'd0);
        chk("model_mulhsu", ref_mul(MULT_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("model_mulh",   ref_mul(MULT_MULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000), 64'h4000_0000_0000_0000);

        // Basic MUL with latency and stall length
        start_op(MULT_MUL, 64'd7, 64'd6, 5'd3);
        wait_done(200, lat, st);
        chk("mul_lat", 64'(lat), 64'd17);
        chk("mul_stall_cycles", 64'(st), 64'd17);
        chk("mul_result", bus.result, 64'd42);
        chk("mul_rd", 64'(bus.rd_out), 64'd3);
        chk("busy_after", 64'(bus.busy), 64'd0);

        run_op("mulh_m1_m1",  MULT_MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        run_op("mulhu_max_2", MULT_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1);
        run_op("mulhsu_m1_2", MULT_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("mul_min_min", MULT_MUL,    64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0);
        run_op("mulh_min_min", MULT_MULH,  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000);

        // Flush at iteration 5, then an immediate restart
        start_op(MULT_MULHU, 64'd123, 64'd456, 5'd7);
        repeat (5) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        chk("flush_keeps_result", bus.result, 64'h4000_0000_0000_0000);
        start_op(MULT_MUL, 64'd1000, 64'd1000, 5'd9);
        wait_done(200, lat, st);
        chk("after_flush_lat", 64'(lat), 64'd17);
        chk("after_flush_result", bus.result, 64'd1000000);
        chk("after_flush_rd", 64'(bus.rd_out), 64'd9);

        // Enable low for 3 cycles mid-CALC, plus an ignored start while busy
        start_op(MULT_MULHU, 64'h0000_0001_0000_0000, 64'h0000_0003_0000_0000, 5'd11);
        repeat (4) @(posedge clk);
        #1 enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 enable = 1'b1;
        bus.start = 1'b1; bus.op = MULT_MUL; bus.operand_a = 64'd5; bus.operand_b = 64'd5; bus.rd_in = 5'd12;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(200, lat, st);
        chk("enable_lat", 64'(lat), 64'd20);
        chk("enable_result", bus.result, 64'd3);
        chk("enable_rd", 64'(bus.rd_out), 64'd11);
        dones = 0;
        for (int k = 0; k < ITER + 3; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("ignored_start_no_done", 64'(dones), 64'd0);
        @(posedge clk);
        #1;

        // Reset mid-CALC
        start_op(MULT_MUL, 64'd9, 64'd9, 5'd4);
        repeat (3) @(posedge clk);
        #1 arst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_busy",   64'(bus.busy), 64'd0);
        chk("rst_done",   64'(bus.done), 64'd0);
        chk("rst_stall",  64'(bus.stall_req), 64'd0);
        chk("rst_result", bus.result, 64'd0);
        chk("rst_rd",     64'(bus.rd_out), 64'd0);
        arst_n = 1'b1;

        // BITS_PER_CYCLE = 1 and 8
        bus1.start = 1'b1; bus1.op = MULT_MUL; bus1.operand_a = 64'd7; bus1.operand_b = 64'd6; bus1.rd_in = 5'd2;
        bus8.start = 1'b1; bus8.op = MULT_MUL; bus8.operand_a = 64'd7; bus8.operand_b = 64'd6; bus8.rd_in = 5'd2;
        @(posedge clk);
        #1 bus1.start = 1'b0; bus8.start = 1'b0;
        t0 = cyc;
        lat1 = -1; lat8 = -1; r1 = 64'd0; r8 = 64'd0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (bus1.done && (lat1 < 0)) begin lat1 = cyc - t0; r1 = bus1.result; end
            if (bus8.done && (lat8 < 0)) begin lat8 = cyc - t0; r8 = bus8.result; end
            if ((lat1 >= 0) && (lat8 >= 0)) break;
        end
        chk("bpc1_lat", 64'(lat1), 64'd65);
        chk("bpc8_lat", 64'(lat8), 64'd9);
        chk("bpc1_result", r1, 64'd42);
        chk("bpc8_result", r8, 64'd42);
        chk("bpc8_rd", 64'(bus8.rd_out), 64'd2);

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
